// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the transmitter state encoding, default bit-timing constants and the
// parity helper used when the parity bit is compiled in.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int OVERSAMPLE_DEF = 16;  // ticks per start/data/parity bit
  localparam int STOP_TICKS_DEF = 16;  // 16 = 1 stop bit, 24 = 1.5, 32 = 2

  // Words narrower than 32 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_calc(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: free-running counter 0..dvsr, one s_tick per wrap.
// Ports: clk_i, rst_i (sync, active-high), dvsr_i (divisor), s_tick_o (1-clk tick).
// Latency: tick is combinational from the counter; a new dvsr applies from the next wrap.
// Backpressure: none; the tick stream never stalls.
module uart_baud_gen #(
  parameter int DVSR_W = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  output logic              s_tick_o
);

  logic [DVSR_W-1:0] cnt_q, cnt_d;
  // The wrap limit is only reloaded at a wrap (and in reset), so lowering dvsr
  // below the current count cannot make the counter run past its limit.
  logic [DVSR_W-1:0] lim_q, lim_d;

  assign s_tick_o = (cnt_q == lim_q);

  always_comb begin
    cnt_d = cnt_q + DVSR_W'(1);
    lim_d = lim_q;
    if (s_tick_o) begin
      cnt_d = '0;
      lim_d = dvsr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lim_q <= dvsr_i;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter draining a FIFO read port: start, DATA_BITS LSB first, optional parity, stop.
// Latency: rd pops in the single IDLE clk; tx leaves idle on the next edge; one frame per word.
// Backpressure: no pop while empty and none while a frame is in flight (at most one per frame).
// Ports: clk, Reset (sync, active-high), dvsr, empty, r_data in; rd, tx, tx_busy, tx_done_tick out.
// Build option: define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int STOP_TICKS = STOP_TICKS_DEF,
  parameter int DVSR_W     = 11,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [DVSR_W-1:0]    dvsr,
  input  logic                 empty,
  input  logic [DATA_BITS-1:0] r_data,
  output logic                 rd,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int TICK_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("PARITY_ODD must be 0 or 1");
  end

  logic s_tick;

  uart_baud_gen #(
    .DVSR_W (DVSR_W)
  ) u_baud (
    .clk_i    (clk),
    .rst_i    (Reset),
    .dvsr_i   (dvsr),
    .s_tick_o (s_tick)
  );

  uart_tx_state_t       state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 pop, done;
  logic                 os_last, stop_last;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign os_last   = s_tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));
  assign stop_last = s_tick && (tick_cnt_q == TICK_W'(STOP_TICKS - 1));

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;
    done       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shreg_d    = r_data;
          tick_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
          // Parity is taken from the whole word now, before the shift register drains it.
          par_d      = parity_calc(32'(r_data), PARITY_ODD != 0);
`endif
          state_d    = START;
        end
      end
      START: begin
        if (os_last) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = DATA;
        end else if (s_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      DATA: begin
        if (os_last) begin
          tick_cnt_d = '0;
          shreg_d    = shreg_q >> 1;
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else if (s_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (os_last) begin
          tick_cnt_d = '0;
          state_d    = STOP;
        end else if (s_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
`endif
      STOP: begin
        if (stop_last) begin
          tick_cnt_d = '0;
          done       = 1'b1;
          state_d    = IDLE;
        end else if (s_tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered but decoded from the next state, so the line level
  // changes on the same edge as the state it belongs to.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Strobes are combinational, so Reset masks them directly within its own cycle.
  assign rd           = pop  && !Reset;
  assign tx_done_tick = done && !Reset;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
module tb_uart_tx_fifo_reader;

  localparam int TB_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 176;
`else
  localparam int FRAME = 160;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic [10:0] dvsr;
  logic        empty;
  logic [7:0]  r_data;
  logic        rd, tx, tx_busy, tx_done_tick;

  always #5 clk = ~clk;

  uart_tx_fifo_reader #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .STOP_TICKS (16),
    .DVSR_W     (11),
    .PARITY_ODD (TB_ODD)
  ) dut (
    .clk          (clk),
    .Reset        (Reset),
    .dvsr         (dvsr),
    .empty        (empty),
    .r_data       (r_data),
    .rd           (rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // FIFO model and scoreboard of words expected on the line
  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];

  task automatic refresh();
    empty  = (fifo.size() == 0);
    r_data = (fifo.size() == 0) ? 8'h00 : fifo[0];
  endtask

  task automatic push_fifo(input logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endtask

  task automatic push_word(input logic [7:0] b);
    exp_q.push_back(b);
    push_fifo(b);
  endtask

  always @(posedge clk) begin
    if (rd === 1'b1) begin
      check("rd_nonempty", {31'd0, empty}, 32'd0);
      #1;
      if (fifo.size() > 0) fifo.delete(0);
      refresh();
    end
  end

  // Event recorder (cycle stamps of rd and done pulses)
  int cyc = 0, rd_cnt = 0, done_cnt = 0;
  int rd_cyc_last = 0, rd_cyc_prev = 0, done_cyc_last = 0, done_cyc_prev = 0;

  always @(negedge clk) begin
    cyc++;
    if (rd === 1'b1) begin
      rd_cyc_prev = rd_cyc_last;
      rd_cyc_last = cyc;
      rd_cnt++;
    end
    if (tx_done_tick === 1'b1) begin
      done_cyc_prev = done_cyc_last;
      done_cyc_last = cyc;
      done_cnt++;
    end
  end

  // Line monitor: decodes frames mid-bit and checks them against the scoreboard
  int   bit_clks = 16;
  bit   mon_en   = 1'b1;
  logic last_par = 1'b0;

  initial begin : monitor
    logic       prev;
    logic [7:0] got, want;
    logic       p;
    prev = 1'b1;
    p    = 1'b0;
    got  = '0;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && tx === 1'b0) begin
        repeat (bit_clks / 2) @(negedge clk);
        check("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clks) @(negedge clk);
          got[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (bit_clks) @(negedge clk);
        p        = tx;
        last_par = p;
`endif
        repeat (bit_clks) @(negedge clk);
        check("stop_bit", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got 0x%02h, expected no frame", got);
        end else begin
          want = exp_q.pop_front();
          check("frame_data", {24'd0, got}, {24'd0, want});
`ifdef UART_TX_PARITY_EN
          check("frame_parity", {31'd0, p}, {31'd0, (^want) ^ TB_ODD[0]});
`endif
        end
      end
      prev = tx;
    end
  end

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic wait_rd(input int target, input int budget, input string name);
    int n = 0;
    while (rd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, rd_cnt >= target}, 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, r0, n, v_tx, v_rd, v_busy;
    Reset  = 1'b1;
    dvsr   = '0;
    empty  = 1'b1;
    r_data = '0;

    // reset state, and reset overriding a non-empty FIFO
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_rd", {31'd0, rd}, 32'd0);
    check("reset_done", {31'd0, tx_done_tick}, 32'd0);
    push_word(8'hA5);
    @(negedge clk);
    check("reset_rd_nonempty", {31'd0, rd}, 32'd0);
    Reset = 1'b0;

    // single word 0xA5
    repeat (80) @(negedge clk);
    check("t1_busy_mid", {31'd0, tx_busy}, 32'd1);
    wait_done(1, 400, "t1_done_seen");
    check("t1_rd_count", rd_cnt, 1);
    check("t1_done_latency", done_cyc_last - rd_cyc_last, FRAME);
    repeat (4) @(negedge clk);

    // 0x00 then 0xFF back to back
    push_word(8'h00);
    push_word(8'hFF);
    wait_done(3, 800, "t2_done_seen");
    check("t2_rd_count", rd_cnt, 3);
    check("t2_rd_spacing", rd_cyc_last - rd_cyc_prev, FRAME + 1);
    check("t2_done_spacing", done_cyc_last - done_cyc_prev, FRAME + 1);
    check("t2_idle_gap", rd_cyc_last - done_cyc_prev, 1);
    repeat (4) @(negedge clk);

    // empty held for 1000 clks
    v_tx = 0; v_rd = 0; v_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) v_tx++;
      if (rd !== 1'b0) v_rd++;
      if (tx_busy !== 1'b0) v_busy++;
    end
    check("t3_tx_not_idle", v_tx, 0);
    check("t3_spurious_rd", v_rd, 0);
    check("t3_spurious_busy", v_busy, 0);

    // reset in DATA bit 3: word 0x5A is lost, 0x81 follows after reset
    mon_en = 1'b0;
    push_fifo(8'h5A);
    wait_rd(4, 50, "t4_rd_seen");
    repeat (71) @(negedge clk);
    Reset = 1'b1;
    push_word(8'h81);
    d0 = done_cnt;
    r0 = rd_cnt;
    @(negedge clk);
    check("t4_tx_after_reset", {31'd0, tx}, 32'd1);
    check("t4_busy_after_reset", {31'd0, tx_busy}, 32'd0);
    check("t4_no_done", {31'd0, tx_done_tick}, 32'd0);
    check("t4_no_rd", {31'd0, rd}, 32'd0);
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_done_count_held", done_cnt, d0);
    check("t4_rd_count_held", rd_cnt, r0);
    Reset = 1'b0;
    wait_done(d0 + 1, 400, "t4_done_after_reset");
    check("t4_rd_after_reset", rd_cnt, r0 + 1);
    repeat (4) @(negedge clk);

    // dvsr=3: back-to-back 0x3C frames, then dvsr->1 mid-frame
    dvsr     = 11'd3;
    bit_clks = 64;
    d0       = done_cnt;
    push_word(8'h3C);
    push_word(8'h3C);
    wait_done(d0 + 2, 3000, "t5_done_seen");
    check("t5_frame_clks", done_cyc_last - done_cyc_prev, 4 * FRAME);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    r0 = rd_cnt;
    d0 = done_cnt;
    push_fifo(8'h3C);
    wait_rd(r0 + 1, 100, "t5_rd_seen");
    repeat (100) @(negedge clk);
    dvsr = 11'd1;
    n = 0;
    while (tx !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (tx === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t5_ones_run_after_dvsr1", n, 128);
    wait_done(d0 + 1, 1000, "t5_done_after_change");
    dvsr     = '0;
    bit_clks = 16;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
    // parity on 0x07
    d0 = done_cnt;
    push_word(8'h07);
    wait_done(d0 + 1, 400, "t6_done_seen");
    check("t6_frame_clks", done_cyc_last - rd_cyc_last, 176);
    check("t6_parity_bit", {31'd0, last_par}, (TB_ODD != 0) ? 32'd0 : 32'd1);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
